// File: rtl/cla_pkg.sv
// Shared constants and nibble propagate/generate helper for the pipelined 16-bit CLA adder.
package cla_pkg;

    localparam int WIDTH = 16;
    localparam int NIB   = 4;
    localparam int NNIB  = 4;

    localparam logic [NNIB-1:0]  PBQ_RST = '1;
    localparam logic [NNIB-1:0]  GBQ_RST = '1;
    localparam logic [WIDTH-1:0] SUM_RST = '0;

    typedef struct packed {
        logic p;
        logic g;
    } nib_pg_t;

    // Group propagate needs every bit to propagate; group generate ripples from bit 0 upward.
    function automatic nib_pg_t nib_pg(input logic [NIB-1:0] a, input logic [NIB-1:0] b);
        logic [NIB-1:0] p;
        logic [NIB-1:0] g;
        nib_pg_t r;
        p   = a | b;
        g   = a & b;
        r.p = &p;
        r.g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return r;
    endfunction

endpackage

// File: rtl/cla_adder_pipe16_if.sv
// Operand/result bus of the pipelined CLA adder; ovf exists only when CLA_OVF_EN is defined.
interface cla_adder_pipe16_if;
    import cla_pkg::*;

    // Handshake: a beat moves when valid and ready are both high at a rising clk edge;
    // a source holds its payload and valid steady until that edge.
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cn;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [NNIB-1:0]  pbq;
    logic [NNIB-1:0]  gbq;
`ifdef CLA_OVF_EN
    logic             ovf;
`endif

    modport master (
        output a, b, cn, in_valid, out_ready,
`ifdef CLA_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, pbq, gbq
    );

    modport slave (
        input  a, b, cn, in_valid, out_ready,
`ifdef CLA_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, pbq, gbq
    );

endinterface

// File: rtl/cla_lookahead4.sv
// Four-nibble carry-lookahead unit: active-low group P/G in, active-high carries out.
module cla_lookahead4
    import cla_pkg::*;
(
    input  logic [NNIB-1:0] pb,
    input  logic [NNIB-1:0] gb,
    input  logic            cn,
    output logic            c1,
    output logic            c2,
    output logic            c3,
    output logic            cout
);

    logic [NNIB-1:0] p;
    logic [NNIB-1:0] g;

    assign p = ~pb;
    assign g = ~gb;

    assign c1   = g[0] | (p[0] & cn);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cn);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cn);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cn);

endmodule

// File: rtl/cla_adder_pipe16.sv
// Two-stage pipelined 16-bit carry-lookahead adder with valid/ready flow control.
// Optional registered signed-overflow output when CLA_OVF_EN is defined.
module cla_adder_pipe16
    import cla_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    cla_adder_pipe16_if.slave bus
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cn;
    logic [NNIB-1:0]  pbq_q;
    logic [NNIB-1:0]  gbq_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             s2_advance;
    logic             in_ready;
    logic             s1_load;
    logic [NNIB-1:0]  p_nib;
    logic [NNIB-1:0]  g_nib;
    logic [NNIB:0]    carry;
    logic [WIDTH-1:0] sum_next;

    // S2 can take a new beat when empty or draining; S1 can when empty or emptying into S2.
    assign s2_advance = ~out_valid_q | bus.out_ready;
    assign in_ready   = ~rst & (~s1_valid | s2_advance);
    assign s1_load    = bus.in_valid & in_ready;

    for (genvar i = 0; i < NNIB; i++) begin : g_pg
        assign {p_nib[i], g_nib[i]} = nib_pg(bus.a[i*NIB +: NIB], bus.b[i*NIB +: NIB]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cn    <= 1'b0;
            pbq_q    <= PBQ_RST;
            gbq_q    <= GBQ_RST;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_cn    <= bus.cn;
            pbq_q    <= ~p_nib;
            gbq_q    <= ~g_nib;
        end else if (s2_advance) begin
            s1_valid <= 1'b0;
        end
    end

    assign carry[0] = s1_cn;

    cla_lookahead4 u_lookahead (
        .pb   (pbq_q),
        .gb   (gbq_q),
        .cn   (s1_cn),
        .c1   (carry[1]),
        .c2   (carry[2]),
        .c3   (carry[3]),
        .cout (carry[4])
    );

    for (genvar i = 0; i < NNIB; i++) begin : g_sum
        assign sum_next[i*NIB +: NIB] = s1_a[i*NIB +: NIB] + s1_b[i*NIB +: NIB]
                                      + {{(NIB-1){1'b0}}, carry[i]};
    end

`ifdef CLA_OVF_EN
    logic ovf_q;
    logic c15;

    // Carry into the sign bit recovered from the sign-bit sum itself.
    assign c15 = s1_a[WIDTH-1] ^ s1_b[WIDTH-1] ^ sum_next[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (s2_advance && s1_valid) begin
            ovf_q <= carry[NNIB] ^ c15;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= SUM_RST;
            cout_q      <= 1'b0;
        end else if (s2_advance) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                sum_q  <= sum_next;
                cout_q <= carry[NNIB];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.pbq       = pbq_q;
    assign bus.gbq       = gbq_q;

endmodule

// File: doc/cla_adder_pipe16.md
CLA_ADDER_PIPE16 -- requirements
Module: cla_adder_pipe16

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset, sampled on the CLK rising edge.
REQ-003 SHALL have port A, input, 16, operand A (unsigned / two's complement).
REQ-004 SHALL have port B, input, 16, operand B.
REQ-005 SHALL have port CN, input, 1, active-high carry-in.
REQ-006 SHALL have port IN_VALID, input, 1, upstream offers A/B/CN.
REQ-007 SHALL have port IN_READY, output, 1, block accepts this cycle.
REQ-008 SHALL have port OUT_VALID, output, 1, SUM/COUT valid.
REQ-009 SHALL have port OUT_READY, input, 1, downstream accepts.
REQ-010 SHALL have port SUM, output, 16, A+B+CN mod 2^16.
REQ-011 SHALL have port COUT, output, 1, carry out of bit 15.
REQ-012 SHALL have port PBQ, output, 4, registered active-low nibble propagate (PBQ[i]=0 means nibble i propagates).
REQ-013 SHALL have port GBQ, output, 4, registered active-low nibble generate.

Function
REQ-014 SHALL be a two-stage pipeline: S1 registers operands, CN and the nibble P/G; S2 registers SUM/COUT.
REQ-015 SHALL compute, in S1, nibble propagate as the AND of the four bit-propagates (a|b) and nibble generate as standard ripple generate, and store both inverted into PBQ/GBQ.
REQ-016 SHALL derive, in S2, the nibble carries from the registered PBQ/GBQ/CN: C1=G0|P0&CN, C2=G1|P1&G0|P1&P0&CN, C3 likewise, COUT=G3|P3&G2|P3&P2&G1|P3&P2&P1&G0|P3&P2&P1&P0&CN.
REQ-017 SHALL produce each nibble sum as A_nib+B_nib+C_i, using the carry from REQ-016.
REQ-018 SHALL treat a transfer as occurring when VALID and READY are both high on the same edge.
REQ-019 SHALL give a latency of exactly 2 cycles from input transfer to OUT_VALID high when there is no backpressure.
REQ-020 SHALL sustain one transfer per cycle while OUT_READY is held high.
REQ-021 SHALL drive IN_READY = ~s1_valid | s2_advance, where s2_advance = ~OUT_VALID | OUT_READY; IN_READY SHALL be combinational from OUT_READY.
REQ-022 SHALL hold SUM, COUT and OUT_VALID stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 SHALL ignore A/B/CN when IN_VALID=0 and leave S1 unchanged; PBQ/GBQ SHALL change only on an S1 load.
REQ-024 SHALL, on a simultaneous output and input transfer with both stages full, move S1 to S2 and load S1 in the same edge, with no bubble and no loss.
REQ-025 SHALL retain at most 2 transactions in flight.

Reset
REQ-026 SHALL, on RST, clear the S1 and S2 valid flags, set SUM=0, COUT=0, PBQ=4'hF and GBQ=4'hF; OUT_VALID SHALL be 0 in the following cycle.
REQ-027 SHALL discard in-flight transactions when RST is asserted mid-operation and accept no input while RST=1 (IN_READY=0).

Configuration
REQ-028 SHALL, when CLA_OVF_EN is defined, add output OVF (1 bit), the registered signed overflow (COUT xor carry into bit 15), with reset value 0, stalled like SUM.
REQ-029 SHALL, when CLA_OVF_EN is undefined, have no OVF port and leave all other behaviour identical.

Structure
REQ-030 SHALL place WIDTH=16, NIB=4, NNIB=4 and the reset constants in package cla_pkg.
REQ-031 SHALL use one combinational sub-module, cla_lookahead4 (active-low PB/GB in, active-high CN, C1..C3 and COUT out), instantiated once in S2.

Verification
REQ-032 SHALL cover: A=16'h00FF, B=16'h0001, CN=0 -> after 2 cycles SUM=16'h0100, COUT=0.
REQ-033 SHALL cover: A=16'hFFFF, B=16'h0000, CN=1 -> SUM=16'h0000, COUT=1; S1 PBQ=4'h0, GBQ=4'hF.
REQ-034 SHALL cover: 3 back-to-back inputs with OUT_READY low for 3 cycles -> IN_READY drops after 2 accepts, SUM holds the first result, and all 3 results emerge in order.
REQ-035 SHALL cover: RST asserted with 2 in flight -> OUT_VALID=0 next cycle, SUM=0, and no stale output afterwards.
REQ-036 SHALL cover: with CLA_OVF_EN, A=16'h7FFF, B=16'h0001 -> SUM=16'h8000, OVF=1, COUT=0.
REQ-037 SHALL cover: 10k random A/B/CN with random OUT_READY -> every SUM/COUT matches a 17-bit reference add, in order.
